demux_32_1_4_reg: RTL and testbench

//  Registered 1-to-4 demultiplexer with valid/ready handshake, the steering counterpart
//  of the 32-bit 4:1 select muxes. Routes one 32-bit word per cycle from a single

---
 rtl/demux_32_1_4_reg.sv | 114 +++++++++++
 tb/tb_demux_32_1_4_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_32_1_4_reg.sv
// demux_32_1_4_reg: registered 1-to-4 steering demux with valid/ready handshake.
// Each output channel owns a one-entry holding slot, so a stalled consumer only
// blocks words addressed to it. At most one slot loads per cycle; any number drain.
module demux_32_1_4_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [2:0]       pending_cnt
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state_q [4];
  slot_state_e      state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [WIDTH-1:0] data_d  [4];
  logic [2:0]       cnt_q;
  logic [2:0]       cnt_d;

  logic [3:0]       acc_s;
  logic [3:0]       drain_s;
  logic             sel_full_s;

  // Number of set bits in a 4-bit drain vector (0..4).
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Handshake decode: ready depends only on the addressed slot.
  always_comb begin
    sel_full_s = (state_q[in_sel] == ST_FULL);
    in_ready   = ~sel_full_s | out_ready[in_sel];
    for (int k = 0; k < 4; k++) begin
      drain_s[k] = (state_q[k] == ST_FULL) & out_ready[k];
      acc_s[k]   = in_valid & in_ready & (in_sel == 2'(k));
    end
  end

  // Per-slot next state and data; a drained slot keeps its old data.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      case (state_q[k])
        ST_EMPTY: begin
          if (acc_s[k]) begin
            state_d[k] = ST_FULL;
            data_d[k]  = in_data;
          end else begin
            state_d[k] = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (acc_s[k]) begin
            state_d[k] = ST_FULL;
            data_d[k]  = in_data;
          end else if (drain_s[k]) begin
            state_d[k] = ST_EMPTY;
          end else begin
            state_d[k] = ST_FULL;
          end
        end
        default: begin
          state_d[k] = ST_EMPTY;
        end
      endcase
    end
    cnt_d = cnt_q + {2'b00, |acc_s} - popcount4(drain_s);
  end

  // Slot state, slot data and occupancy count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= ST_EMPTY;
        data_q[k]  <= {WIDTH{1'b0}};
      end
      cnt_q <= 3'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      out_valid[k] = (state_q[k] == ST_FULL);
    end
    out_data0   = data_q[0];
    out_data1   = data_q[1];
    out_data2   = data_q[2];
    out_data3   = data_q[3];
    pending_cnt = cnt_q;
  end

endmodule

// File: tb/tb_demux_32_1_4_reg.sv
// tb_demux_32_1_4_reg: directed scenarios plus randomized traffic, all checked
// against a slot-level reference model (full flags, held words, occupancy).
module tb_demux_32_1_4_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0;
  logic [31:0] out_data1;
  logic [31:0] out_data2;
  logic [31:0] out_data3;
  logic [2:0]  pending_cnt;

  int checks;
  int failures;

  // reference model
  bit          m_full [4];
  logic [31:0] m_data [4];

  demux_32_1_4_reg #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_data(input int k);
    case (k)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      default: return out_data3;
    endcase
  endfunction

  function automatic int model_cnt();
    int n = 0;
    for (int k = 0; k < 4; k++) n += m_full[k] ? 1 : 0;
    return n;
  endfunction

  function automatic bit model_ready(input logic [1:0] s, input logic [3:0] rdy);
    return !m_full[s] || rdy[s];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = 32'h0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] ev;
    for (int k = 0; k < 4; k++) ev[k] = m_full[k];
    check({tag, ".valid"}, {28'h0, out_valid}, {28'h0, ev});
    for (int k = 0; k < 4; k++) check($sformatf("%s.data%0d", tag, k), dut_data(k), m_data[k]);
    check({tag, ".cnt"}, {29'h0, pending_cnt}, model_cnt());
  endtask

  // One clock cycle: called at posedge+1, drives inputs, checks in_ready,
  // advances the model, then checks registered outputs after the edge.
  task automatic cycle(input bit v, input logic [1:0] s, input logic [31:0] d,
                       input logic [3:0] rdy, input string tag, output bit accepted);
    bit exp_rdy;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = rdy;
    #1;
    exp_rdy = model_ready(s, rdy);
    check({tag, ".in_ready"}, {31'h0, in_ready}, {31'h0, exp_rdy});
    accepted = v && exp_rdy;
    for (int k = 0; k < 4; k++) begin
      if (accepted && s == 2'(k)) begin
        m_full[k] = 1'b1;
        m_data[k] = d;
      end else if (m_full[k] && rdy[k]) begin
        m_full[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    bit          acc;
    bit          hold;
    logic [1:0]  hs;
    logic [31:0] hd;
    logic [31:0] words [16];
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 2'b00;
    in_data   = 32'h0;
    out_ready = 4'b0000;
    model_clear();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // basic route
    cycle(1'b1, 2'b01, 32'hDEADBEEF, 4'b0000, "route", acc);
    check("route.valid_const", {28'h0, out_valid}, 32'h2);
    check("route.data1_const", out_data1, 32'hDEADBEEF);
    cycle(1'b1, 2'b01, 32'h11111111, 4'b0000, "route_blocked", acc);
    check("route_blocked.acc", {31'h0, acc}, 32'h0);

    // isolation: ch1 stalled, ch3 still accepts
    cycle(1'b1, 2'b11, 32'h00001234, 4'b0000, "iso", acc);
    check("iso.cnt_const", {29'h0, pending_cnt}, 32'd2);
    check("iso.data1_const", out_data1, 32'hDEADBEEF);

    // simultaneous accept + drain on ch0
    cycle(1'b1, 2'b00, 32'hA5A5A5A5, 4'b0000, "ad_load", acc);
    cycle(1'b1, 2'b00, 32'h5A5A5A5A, 4'b0001, "ad", acc);
    check("ad.data0_const", out_data0, 32'h5A5A5A5A);
    check("ad.cnt_const", {29'h0, pending_cnt}, 32'd3);

    // fill all four slots
    cycle(1'b0, 2'b00, 32'h0, 4'b1111, "drain_all", acc);
    for (int k = 0; k < 4; k++) cycle(1'b1, 2'(k), 32'(k + 1), 4'b0000, "fill", acc);
    check("fill.cnt_const", {29'h0, pending_cnt}, 32'd4);
    in_valid  = 1'b1;
    out_ready = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check($sformatf("fill.in_ready_sel%0d", s), {31'h0, in_ready}, 32'h0);
    end
    cycle(1'b0, 2'b00, 32'h0, 4'b1111, "empty_all", acc);
    check("empty_all.valid_const", {28'h0, out_valid}, 32'h0);

    // streaming 16 words into ch2
    for (int i = 0; i < 16; i++) begin
      words[i] = $urandom;
      cycle(1'b1, 2'b10, words[i], 4'b0100, "stream", acc);
      check("stream.acc", {31'h0, acc}, 32'h1);
      check("stream.data2", out_data2, words[i]);
    end
    cycle(1'b0, 2'b00, 32'h0, 4'b0100, "stream_end", acc);

    // randomized traffic honouring the hold rule
    hold = 1'b0;
    hs   = 2'b00;
    hd   = 32'h0;
    for (int i = 0; i < 400; i++) begin
      bit          v;
      logic [1:0]  s;
      logic [31:0] d;
      if (hold) begin
        v = 1'b1; s = hs; d = hd;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        s = 2'($urandom_range(0, 3));
        d = $urandom;
      end
      cycle(v, s, d, 4'($urandom_range(0, 15)), "rand", acc);
      hold = v && !acc;
      hs   = s;
      hd   = d;
    end

    // asynchronous reset mid-cycle with ch2 full
    cycle(1'b0, 2'b00, 32'h0, 4'b1111, "pre_rst", acc);
    cycle(1'b1, 2'b10, 32'hCAFEF00D, 4'b0000, "rst_load", acc);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_outputs("async_rst");
    check("async_rst.data2_const", out_data2, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 2'b00, 32'h0, 4'b0000, "post_rst", acc);
    check("post_rst.valid_const", {28'h0, out_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
